// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result bus of the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: a - b - bin computed one DIGIT-wide slice per clock with a registered borrow chain
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic clk,
    input logic rst_n,
    serial_subtractor_if.slave s
);
    localparam int NUM = WIDTH / DIGIT;
    localparam int CW  = NUM > 1 ? $clog2(NUM) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_res, r_diff, w_res;
    logic [CW-1:0]    r_cnt;
    logic             r_br, r_bout, r_ovf;
    logic             w_accept, w_last, w_br;
    logic [DIGIT-1:0] w_d;
    // start is honoured only when no operation is in flight (IDLE or the one-cycle DONE)
    assign w_accept = s.start && (r_state == IDLE || r_state == DONE);
    assign w_last   = r_cnt == CW'(NUM - 1);
    // one DIGIT-wide subtract cell; the extra top bit is the slice borrow-out
    assign {w_br, w_d} = {1'b0, r_a[r_cnt*DIGIT +: DIGIT]} - {1'b0, r_b[r_cnt*DIGIT +: DIGIT]} - {{DIGIT{1'b0}}, r_br};
    assign s.busy = r_state == RUN;
    assign s.done = r_state == DONE;
    assign s.diff = r_diff;
    assign s.bout = r_bout;
    assign s.ovf  = r_ovf;
    // merge the current slice into the partial result so the last edge can publish it directly
    always_comb begin
        w_res = r_res;
        w_res[r_cnt*DIGIT +: DIGIT] = w_d;
    end
    // next state: RUN until the last slice, DONE for one cycle, restart straight from DONE on start
    always_comb begin
        w_next = r_state;
        w_next = r_state == RUN ? (w_last ? DONE : RUN) : (w_accept ? RUN : IDLE);
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // operand capture, slice iteration and result publication on the final slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= s.a;
            r_b   <= s.b;
            r_br  <= s.bin;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_res <= w_res;
            r_br  <= w_br;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff <= w_res;
                r_bout <= w_br;
                r_ovf  <= (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
            end
        end
    end
endmodule
